// File: rtl/mem_pipe_if.sv
// -----------------------------------------------------------------------------
// mem_pipe_if
// Data-memory request/acknowledge bus between the MEM stage and data memory.
//   req   : access request, held high until ack or abort
//   we    : 1 = write, 0 = read (valid while req is high)
//   addr  : byte address (valid while req is high)
//   wdata : write data (valid while req is high)
//   ack   : memory completes the access this cycle
//   rdata : read data, valid while ack is high
// Modports: master (MEM stage), slave (memory).
// -----------------------------------------------------------------------------
interface mem_pipe_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, we, addr, wdata, input ack, rdata);
  modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/mem_pipe.sv
// -----------------------------------------------------------------------------
// mem_pipe
// MEM pipeline stage. Consumes the X/M pipeline registers, performs integer
// and FP loads/stores over the dmem request/ack bus, stalls upstream while an
// access is outstanding and produces the M/W pipeline registers.
//
// Ports
//   clk, rst           : clock, synchronous active-high reset
//   *_xm               : X/M pipeline register inputs from EX
//   dmem (master)      : data-memory request/ack bus
//   stall_o            : upstream must hold X/M stable while high
//   pc_src_o           : branch taken, straight from X/M
//   branch_target_o    : branch target, straight from X/M
//   *_mw, mem_data_*   : M/W pipeline registers for writeback/forwarding
//   err_o              : sticky access-timeout flag
// -----------------------------------------------------------------------------
module mem_pipe #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_to_reg_xm,
  input  logic        reg_write_xm,
  input  logic        mem_read_xm,
  input  logic        mem_write_xm,
  input  logic        fp_operation_xm,
  input  logic        branch_xm,
  input  logic [31:0] branch_addr_xm,
  input  logic [31:0] alu_out_xm,
  input  logic [31:0] alu_out_fp_xm,
  input  logic [4:0]  rd_addr_xm,
  input  logic [31:0] mem_data_xm,
  input  logic [31:0] mem_data_fp_xm,
  mem_pipe_if.master  dmem,
  output logic        stall_o,
  output logic        pc_src_o,
  output logic [31:0] branch_target_o,
  output logic        mem_to_reg_mw,
  output logic        reg_write_mw,
  output logic        fp_operation_mw,
  output logic [4:0]  rd_addr_mw,
  output logic [31:0] alu_out_mw,
  output logic [31:0] alu_out_fp_mw,
  output logic [31:0] mem_data_to_reg,
  output logic [31:0] mem_data_to_reg_fp,
  output logic        err_o
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [31:0]        rdata_q;
  logic               req_q;
  logic               we_q;
  logic [31:0]        addr_q;
  logic [31:0]        wdata_q;
  logic               err_q;

  logic               mem_to_reg_q;
  logic               reg_write_q;
  logic               fp_operation_q;
  logic [4:0]         rd_addr_q;
  logic [31:0]        alu_out_q;
  logic [31:0]        alu_out_fp_q;
  logic [31:0]        mem_data_q;
  logic [31:0]        mem_data_fp_q;

  logic               acc;

  assign acc = mem_read_xm | mem_write_xm;

  // Stall is raised in the issuing cycle already so EX holds the X/M
  // registers until the access has fully completed.
  assign stall_o = ((state_q == IDLE) && acc) || (state_q == BUSY);

  // Branch resolution bypasses the stage and ignores stalls.
  assign pc_src_o        = branch_xm;
  assign branch_target_o = branch_addr_xm;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      rdata_q        <= '0;
      req_q          <= 1'b0;
      we_q           <= 1'b0;
      addr_q         <= '0;
      wdata_q        <= '0;
      err_q          <= 1'b0;
      mem_to_reg_q   <= 1'b0;
      reg_write_q    <= 1'b0;
      fp_operation_q <= 1'b0;
      rd_addr_q      <= '0;
      alu_out_q      <= '0;
      alu_out_fp_q   <= '0;
      mem_data_q     <= '0;
      mem_data_fp_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (acc) begin
            state_q <= BUSY;
            cnt_q   <= '0;
            req_q   <= 1'b1;
            // A read+write combination is issued as a write.
            we_q    <= mem_write_xm;
            addr_q  <= fp_operation_xm ? alu_out_fp_xm  : alu_out_xm;
            wdata_q <= fp_operation_xm ? mem_data_fp_xm : mem_data_xm;
          end
        end
        BUSY: begin
          // Ack is checked first so a late ack on the final cycle still wins.
          if (dmem.ack) begin
            rdata_q <= dmem.rdata;
            req_q   <= 1'b0;
            state_q <= DONE;
          end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
            req_q   <= 1'b0;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          // Always return to IDLE: the X/M inputs advance on this edge, so
          // the completed access can never be issued twice.
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase

      // M/W register: insert a bubble while stalled, otherwise advance.
      if (stall_o) begin
        reg_write_q  <= 1'b0;
        mem_to_reg_q <= 1'b0;
      end else begin
        mem_to_reg_q   <= mem_to_reg_xm;
        reg_write_q    <= reg_write_xm;
        fp_operation_q <= fp_operation_xm;
        rd_addr_q      <= rd_addr_xm;
        alu_out_q      <= alu_out_xm;
        alu_out_fp_q   <= alu_out_fp_xm;
        if (state_q == DONE) begin
          mem_data_q    <= rdata_q;
          mem_data_fp_q <= rdata_q;
        end
      end
    end
  end

  assign dmem.req   = req_q;
  assign dmem.we    = we_q;
  assign dmem.addr  = addr_q;
  assign dmem.wdata = wdata_q;

  assign mem_to_reg_mw      = mem_to_reg_q;
  assign reg_write_mw       = reg_write_q;
  assign fp_operation_mw    = fp_operation_q;
  assign rd_addr_mw         = rd_addr_q;
  assign alu_out_mw         = alu_out_q;
  assign alu_out_fp_mw      = alu_out_fp_q;
  assign mem_data_to_reg    = mem_data_q;
  assign mem_data_to_reg_fp = mem_data_fp_q;
  assign err_o              = err_q;

endmodule
